// File: rtl/ssd_pkg.sv
// Shared definitions for seven-segment self-check blocks.
package ssd_pkg;

    localparam int unsigned SETTLE_DEFAULT = 4;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned SEG_W          = 7;
    localparam int unsigned NDIG           = 4;

    // Active-low {a,b,c,d,e,f,g} patterns as driven by the display driver
    localparam logic [SEG_W-1:0] SEG_0     = 7'h01;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h4C;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h20;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h0F;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h04;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Decoder result payload
    typedef struct packed {
        logic [3:0] value;
        logic       blank;
        logic       err;
    } seg_dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to BCD decoder.
module seg7_decode
    import ssd_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output seg_dec_t         o_dec_c
);

    // Map each known pattern; anything unrecognised is flagged as an error
    always_comb begin
        o_dec_c = '0;
        case (i_seg)
            SEG_0:     o_dec_c.value = 4'd0;
            SEG_1:     o_dec_c.value = 4'd1;
            SEG_2:     o_dec_c.value = 4'd2;
            SEG_3:     o_dec_c.value = 4'd3;
            SEG_4:     o_dec_c.value = 4'd4;
            SEG_5:     o_dec_c.value = 4'd5;
            SEG_6:     o_dec_c.value = 4'd6;
            SEG_7:     o_dec_c.value = 4'd7;
            SEG_8:     o_dec_c.value = 4'd8;
            SEG_9:     o_dec_c.value = 4'd9;
            SEG_BLANK: o_dec_c.blank = 1'b1;
            default:   o_dec_c.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Samples a multiplexed seven-segment bus, waits for each digit to settle
// and decodes it back to BCD for in-system checking of the display path.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic              f_crys,
    input  logic              rst,
    input  logic [7:0]        D,
    input  logic [NDIG-1:0]   ssd,
    output logic [4*NDIG-1:0] val,
    output logic [NDIG-1:0]   blank,
    output logic [NDIG-1:0]   dp,
    output logic [NDIG-1:0]   err,
    output logic              cap_stb,
    output logic [1:0]        cap_idx,
    output logic              frame_stb
);

    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]        r_dq;
    logic [NDIG-1:0]   r_ssdq;
    logic [11:0]       r_prev_pair;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_cap;
    logic [11:0]       w_pair;
    logic              w_valid;
    logic              w_same;
    logic [1:0]        w_idx;
    seg_dec_t          w_dec;
    logic              r_have_prev;
    logic [1:0]        r_prev_idx;
    logic [4*NDIG-1:0] r_val;
    logic [NDIG-1:0]   r_blank;
    logic [NDIG-1:0]   r_dp;
    logic [NDIG-1:0]   r_err;
    logic              r_cap_stb;
    logic [1:0]        r_cap_idx;
    logic              r_frame_stb;

    assign w_pair = {r_dq, r_ssdq};
    assign w_same = (w_pair == r_prev_pair);

    // One-hot-low select detection and digit index
    always_comb begin
        w_valid = 1'b1;
        w_idx   = 2'd0;
        case (r_ssdq)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_valid = 1'b0;
        endcase
    end

    seg7_decode u_dec (
        .i_seg   (r_dq[7:1]),
        .o_dec_c (w_dec)
    );

    // Input register plus one-cycle-old copy for the stability compare
    always_ff @(posedge f_crys) begin
        if (rst) begin
            r_dq        <= '1;
            r_ssdq      <= '1;
            r_prev_pair <= '1;
        end else begin
            r_dq        <= D;
            r_ssdq      <= ssd;
            r_prev_pair <= w_pair;
        end
    end

    // FSM state and settle counter
    always_ff @(posedge f_crys) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: count stable cycles, capture when the target is reached
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (!w_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_same) begin
                    w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!w_same) begin
                    w_state_nxt = w_valid ? ST_SETTLE : ST_IDLE;
                    w_cnt_nxt   = w_valid ? CNT_W'(1) : '0;
                end else begin
                    w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // A settle window that reaches the target captures and moves to HOLD
        if (w_state_nxt == ST_SETTLE && w_cnt_nxt == CNT_TGT) begin
            w_cap       = 1'b1;
            w_state_nxt = ST_HOLD;
        end
    end

    // Per-digit result registers, capture strobe and frame detection
    always_ff @(posedge f_crys) begin
        if (rst) begin
            r_val       <= '0;
            r_blank     <= '1;
            r_dp        <= '0;
            r_err       <= '0;
            r_cap_stb   <= 1'b0;
            r_cap_idx   <= 2'd0;
            r_frame_stb <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev_idx  <= 2'd0;
        end else begin
            r_cap_stb   <= w_cap;
            r_frame_stb <= 1'b0;
            if (w_cap) begin
                r_cap_idx   <= w_idx;
                r_frame_stb <= r_have_prev && (w_idx <= r_prev_idx);
                r_have_prev <= 1'b1;
                r_prev_idx  <= w_idx;
                r_dp[w_idx] <= ~r_dq[0];
                if (w_dec.err) begin
                    r_err[w_idx]   <= 1'b1;
                    r_blank[w_idx] <= 1'b0;
                end else if (w_dec.blank) begin
                    r_err[w_idx]   <= 1'b0;
                    r_blank[w_idx] <= 1'b1;
                    r_val[{w_idx, 2'b00} +: 4] <= 4'd0;
                end else begin
                    r_err[w_idx]   <= 1'b0;
                    r_blank[w_idx] <= 1'b0;
                    r_val[{w_idx, 2'b00} +: 4] <= w_dec.value;
                end
            end
        end
    end

    assign val       = r_val;
    assign blank     = r_blank;
    assign dp        = r_dp;
    assign err       = r_err;
    assign cap_stb   = r_cap_stb;
    assign cap_idx   = r_cap_idx;
    assign frame_stb = r_frame_stb;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed self-checking bench for ssd_scan_decoder (SETTLE = 4).
module tb_ssd_scan_decoder;

    logic        f_crys;
    logic        rst;
    logic [7:0]  D;
    logic [3:0]  ssd;
    logic [15:0] val;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        cap_stb;
    logic [1:0]  cap_idx;
    logic        frame_stb;

    int n_checks = 0;
    int n_err    = 0;
    int n_cap    = 0;
    int n_frame  = 0;
    int last_frame_idx = -1;
    int cap_mark = 0;

    logic [3:0] scan_sel [4];
    logic [7:0] scan_pat [4];

    ssd_scan_decoder #(.SETTLE(4)) dut (
        .f_crys    (f_crys),
        .rst       (rst),
        .D         (D),
        .ssd       (ssd),
        .val       (val),
        .blank     (blank),
        .dp        (dp),
        .err       (err),
        .cap_stb   (cap_stb),
        .cap_idx   (cap_idx),
        .frame_stb (frame_stb)
    );

    initial f_crys = 1'b0;
    always #5 f_crys = ~f_crys;

    // Advance one clock and sample registered outputs 1ns after the edge
    task automatic tick();
        @(posedge f_crys);
        #1;
        if (cap_stb) n_cap++;
        if (frame_stb) begin
            n_frame++;
            last_frame_idx = int'(cap_idx);
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_val"},   val, 16'h0000);
        check({tag, "_blank"}, 16'(blank), 16'hF);
        check({tag, "_dp"},    16'(dp), 16'h0);
        check({tag, "_err"},   16'(err), 16'h0);
        check({tag, "_stb"},   16'(cap_stb), 16'h0);
        check({tag, "_idx"},   16'(cap_idx), 16'h0);
        check({tag, "_frame"}, 16'(frame_stb), 16'h0);
    endtask

    initial begin
        scan_sel[0] = 4'b1110; scan_sel[1] = 4'b1101;
        scan_sel[2] = 4'b1011; scan_sel[3] = 4'b0111;
        scan_pat[0] = 8'h03;   scan_pat[1] = 8'h0D;
        scan_pat[2] = 8'h49;   scan_pat[3] = 8'h09;

        rst = 1'b1; D = 8'hFF; ssd = 4'hF;
        repeat (3) tick();
        check_reset_vals("reset");

        // Static digit 0 showing "1"
        rst = 1'b0; ssd = 4'b1110; D = 8'h9F;
        repeat (4) tick();
        check("static_no_early_cap", 16'(n_cap), 16'd0);
        tick();
        check("static_cap_stb", 16'(cap_stb), 16'h1);
        check("static_cap_idx", 16'(cap_idx), 16'h0);
        check("static_val",     val, 16'h0001);
        check("static_blank",   16'(blank), 16'hE);
        check("static_dp",      16'(dp), 16'h0);
        check("static_frame",   16'(frame_stb), 16'h0);
        repeat (10) tick();
        check("static_single_cap", 16'(n_cap), 16'd1);

        // Same digit changes to "2": new window, frame on second capture
        D = 8'h25;
        repeat (4) tick();
        check("static2_no_early", 16'(cap_stb), 16'h0);
        tick();
        check("static2_cap_stb", 16'(cap_stb), 16'h1);
        check("static2_val",     val, 16'h0002);
        check("static2_frame",   16'(frame_stb), 16'h1);

        // Scanned display from a fresh reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; n_cap = 0; n_frame = 0; last_frame_idx = -1;
        for (int k = 0; k < 4; k++) begin
            ssd = scan_sel[k]; D = scan_pat[k];
            repeat (10) tick();
        end
        check("scan1_caps",  16'(n_cap), 16'd4);
        check("scan1_frame", 16'(n_frame), 16'd0);
        check("scan1_val",   val, 16'h9530);
        check("scan1_blank", 16'(blank), 16'h0);
        ssd = scan_sel[0]; D = scan_pat[0];
        repeat (10) tick();
        check("scan2_frame_cnt", 16'(n_frame), 16'd1);
        check("scan2_frame_idx", 16'(last_frame_idx), 16'd0);
        for (int k = 1; k < 4; k++) begin
            ssd = scan_sel[k]; D = scan_pat[k];
            repeat (10) tick();
        end
        check("scan2_caps",  16'(n_cap), 16'd8);
        check("scan2_frame", 16'(n_frame), 16'd1);
        check("scan2_val",   val, 16'h9530);

        // Glitch to "8" for 3 cycles during a hold of digit 1
        ssd = 4'b1101; D = 8'h0D;
        repeat (7) tick();
        D = 8'h01;
        repeat (3) tick();
        D = 8'h0D;
        repeat (3) tick();
        ssd = 4'hF;
        repeat (4) tick();
        check("glitch_caps", 16'(n_cap), 16'd9);
        check("glitch_val",  val, 16'h9530);

        // Two digits selected at once is never captured
        ssd = 4'b1100; D = 8'h03;
        repeat (20) tick();
        check("invalid_sel_caps", 16'(n_cap), 16'd9);

        // Undecodable pattern on digit 2 keeps the old value
        ssd = 4'b1011; D = 8'hAA;
        repeat (5) tick();
        check("bad_cap_stb", 16'(cap_stb), 16'h1);
        check("bad_cap_idx", 16'(cap_idx), 16'h2);
        check("bad_err",     16'(err), 16'h4);
        check("bad_val",     val, 16'h9530);
        check("bad_dp",      16'(dp), 16'h4);
        check("bad_blank",   16'(blank), 16'h0);

        // Blank pattern with decimal point lit
        D = 8'hFE;
        repeat (5) tick();
        check("blank_cap_stb", 16'(cap_stb), 16'h1);
        check("blank_blank",   16'(blank), 16'h4);
        check("blank_dp",      16'(dp), 16'h4);
        check("blank_err",     16'(err), 16'h0);
        check("blank_val",     val, 16'h9030);

        // Reset while the digit-1 count is at 3
        ssd = 4'b1101; D = 8'h03;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        cap_mark = n_cap;
        repeat (4) tick();
        check("midrst_no_early", 16'(n_cap - cap_mark), 16'd0);
        tick();
        check("midrst_cap_stb", 16'(cap_stb), 16'h1);
        check("midrst_cap_idx", 16'(cap_idx), 16'h1);
        check("midrst_val",     val, 16'h0000);
        check("midrst_blank",   16'(blank), 16'hD);
        check("midrst_frame",   16'(frame_stb), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ssd_scan_decoder.md
# ssd_scan_decoder

Receive-side counterpart of the board's seven-segment display driver. It samples the multiplexed segment bus `D` and anode bus `ssd` and waits for each displayed digit to be stable. It then decodes each segment pattern back to a BCD value, so the value shown on the display can be checked in-system. It handles both a static single-digit display and a 4-digit scanned display, and sits in the self-check path next to the display driver.

## Interface
- `SETTLE`, default 4: number of consecutive identical sampled cycles required before a digit is captured. Legal range 1–255.
- `f_crys`  in  1  system clock. All logic runs on its rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `D`  in  8  segment bus, active-low, ordered {a,b,c,d,e,f,g,dp}.
- `ssd`  in  4  digit enables, active-low. `ssd[k]`=0 selects digit k.
- `val`  out  16  decoded digits. Digit k is in `val[4k+3:4k]`.
- `blank`  out  4  digit k was captured with all segments a–g off.
- `dp`  out  4  decimal-point state of digit k at its last capture (1 = lit).
- `err`  out  4  digit k's last capture had an undecodable pattern.
- `cap_stb`  out  1  one-cycle pulse marking a capture.
- `cap_idx`  out  2  index of the digit being captured. Valid only while `cap_stb`=1.
- `frame_stb`  out  1  one-cycle pulse marking the end of a scan frame.

## Operation
- **Input register:** `D` and `ssd` are registered once into `{Dq, ssdq}`. All decisions use the registered pair.
- **Valid select:** a select is valid only when `ssdq` is one-hot-low: 1110, 1101, 1011 or 0111. Any other value (1111, 0000, multiple zeros) is not a valid select.
- **FSM states:**
  - IDLE: the select is not valid. The counter is held at 0.
  - SETTLE: the pair is valid and being counted.
  - HOLD: the digit has been captured, and the block waits for the pair to change.
- **IDLE → SETTLE:** on a valid `ssdq`. The counter loads 1.
- **In SETTLE:**
  - If the pair equals the previous cycle's pair, the counter increments.
  - If the pair differs but is still valid, the counter reloads 1 and the state stays SETTLE.
  - If the pair becomes invalid, the state goes to IDLE.
- **Capture:** when the counter reaches `SETTLE`, the digit is captured and the state goes to HOLD.
- **In HOLD:** if the pair changes, go to SETTLE (counter = 1) when the new pair is valid, or to IDLE when it is not. Otherwise stay in HOLD. Exactly one capture occurs per stable window.
- **Decode:** uses `Dq[7:1]` only; `dp` is taken from `Dq[0]`, inverted.

  | Pattern `Dq[7:1]` | Result |
  |---|---|
  | 7'h01 | 0 |
  | 7'h4F | 1 |
  | 7'h12 | 2 |
  | 7'h06 | 3 |
  | 7'h4C | 4 |
  | 7'h24 | 5 |
  | 7'h20 | 6 |
  | 7'h0F | 7 |
  | 7'h00 | 8 |
  | 7'h04 | 9 |
  | 7'h7F | blank |
  | anything else | err |

- **On capture of digit k:**
  - Decoded value → `val` nibble k, with `blank[k]`=0 and `err[k]`=0.
  - Blank pattern → `blank[k]`=1, nibble k = 0, `err[k]`=0.
  - Error pattern → `err[k]`=1, `blank[k]`=0, nibble k unchanged.
  - `dp[k]` is always updated.
  - Fields of all other digits are unchanged.
- **Frame:** `frame_stb` pulses together with `cap_stb` when a previous capture exists since reset and `cap_idx` ≤ the previous `cap_idx`. A static single-digit display therefore produces a frame on every capture after the first.

## Timing
- **Reset values:** `val`=0, `blank`=4'b1111, `dp`=0, `err`=0, `cap_stb`=0, `cap_idx`=0, `frame_stb`=0. The FSM is in IDLE, the counter is 0, and the "previous capture" record is cleared.
- **Capture latency:** if `D`/`ssd` are constant and valid from rising edge t onward, `cap_stb` is high in the cycle starting at edge t+`SETTLE`+1. `val`/`blank`/`dp`/`err` show the new value in that same cycle.
- **Change during settling:** any change of the pair restarts the count, so a glitch shorter than `SETTLE` cycles is never captured.
- **Reset during settling:** `rst` clears the count. A full `SETTLE` window is required after reset is released.
- **Counter width:** the counter is 8 bits and saturates in HOLD; it never wraps.
- **Stability check:** the stable-window check is an exact 12-bit equality on {`Dq`, `ssdq`}.

## Structure
- A shared package `ssd_pkg` holds:
  - the 11 segment-pattern constants;
  - the FSM state enum {IDLE, SETTLE, HOLD};
  - the default `SETTLE`.
- Sub-module `seg7_decode`: combinational, `Dq[7:1]` → {value[3:0], blank, err}. It is reusable by other self-check blocks.
- The top module contains the input register, FSM, counter, per-digit output registers and frame logic.

## Test plan
- **Static display:** `SETTLE`=4, `ssd`=1110, `D`=8'h9F held after reset.
  - One `cap_stb` with `cap_idx`=0 and `val[3:0]`=1, `blank`=4'b1110, no `frame_stb`.
  - Then change `D` to 8'h25: second capture with `val[3:0]`=2 and `frame_stb`=1.
- **Scanned display:** cycle `ssd` 1110/1101/1011/0111 with `D` = 8'h03/8'h0D/8'h49/8'h09, 10 cycles each.
  - `val`=16'h9530.
  - `frame_stb` on the digit-0 capture of the second scan.
- **Glitch:** in the middle of a hold, `D`=8'h01 for 3 cycles, then the original pattern returns.
  - No capture of 8, and no extra `cap_stb` when the original pattern returns.
- **Invalid select and bad pattern:**
  - `ssd`=1100 for 20 cycles gives no `cap_stb`.
  - `ssd`=1011 with `D`=8'hAA gives `err[2]`=1 and `val[11:8]` unchanged.
  - `D`=8'hFE gives `blank[2]`=1, `dp[2]`=1, `err[2]`=0.
- **Reset mid-settle:** assert `rst` at count 3 of a stable 8'h03 on digit 1.
  - All outputs return to their reset values.
  - After release, `cap_stb` arrives exactly `SETTLE`+1 cycles later.
